// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - shared op-bus layout, unit select indices and dispatch state type
package dispatch_pkg;

   // One-hot decoded op bus width and unit-select width
   localparam int CIRNO_DEC_OPB_SIZE = 28;
   localparam int CIRNO_DEC_USELE    = 3;

   // Unit select bit positions (one-hot)
   localparam int USELE_ALU = 0;
   localparam int USELE_BJU = 1;
   localparam int USELE_LSU = 2;

   // Op bus bit positions
   localparam int OPB_LUI   = 0;
   localparam int OPB_AUIPC = 1;
   localparam int OPB_JAL   = 2;
   localparam int OPB_JALR  = 3;
   localparam int OPB_BEQ   = 4;
   localparam int OPB_BNE   = 5;
   localparam int OPB_BLT   = 6;
   localparam int OPB_BGE   = 7;
   localparam int OPB_BLTU  = 8;
   localparam int OPB_BGEU  = 9;
   localparam int OPB_LB    = 10;
   localparam int OPB_LH    = 11;
   localparam int OPB_LW    = 12;
   localparam int OPB_LBU   = 13;
   localparam int OPB_LHU   = 14;
   localparam int OPB_SB    = 15;
   localparam int OPB_SH    = 16;
   localparam int OPB_SW    = 17;
   localparam int OPB_ADD   = 18;
   localparam int OPB_SUB   = 19;
   localparam int OPB_SLL   = 20;
   localparam int OPB_SLT   = 21;
   localparam int OPB_SLTU  = 22;
   localparam int OPB_XOR   = 23;
   localparam int OPB_SRL   = 24;
   localparam int OPB_SRA   = 25;
   localparam int OPB_OR    = 26;
   localparam int OPB_AND   = 27;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_TRAP = 1'b1
   } disp_state_e;

   // True when the op/unit combination produces a register result
   function automatic logic rd_writes(input logic [CIRNO_DEC_OPB_SIZE-1:0] opb,
                                      input logic [CIRNO_DEC_USELE-1:0]    usele);
      logic is_load;
      logic is_link;
      is_load = opb[OPB_LB] | opb[OPB_LH] | opb[OPB_LW] | opb[OPB_LBU] | opb[OPB_LHU];
      is_link = opb[OPB_JAL] | opb[OPB_JALR] | opb[OPB_AUIPC];
      return usele[USELE_ALU] | (usele[USELE_LSU] & is_load) | (usele[USELE_BJU] & is_link);
   endfunction

endpackage

// File: rtl/dispatch_sb.sv
// rtl/dispatch_sb.sv - 32-entry register pending scoreboard with writeback bypass
module dispatch_sb
   import dispatch_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_set_en,
   input  logic [4:0] i_set_idx,
   input  logic       i_clr_en,
   input  logic [4:0] i_clr_idx,
   input  logic [4:0] i_rs1_idx,
   input  logic [4:0] i_rs2_idx,
   input  logic [4:0] i_rd_idx,
   output logic       o_rs1_pend,
   output logic       o_rs2_pend,
   output logic       o_rd_pend
);

   logic [31:0] pend_q;
   logic [31:0] pend_d;
   logic [31:0] pend_byp;
   logic [31:0] set_mask;
   logic [31:0] clr_mask;

   // Queries see the vector after this cycle's writeback; a same-index set beats the clear
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (i_set_en) set_mask[i_set_idx] = 1'b1;
      if (i_clr_en) clr_mask[i_clr_idx] = 1'b1;
      pend_byp    = pend_q & ~clr_mask;
      pend_byp[0] = 1'b0;
      pend_d      = pend_byp | set_mask;
      pend_d[0]   = 1'b0;
   end

   // Pending vector register; x0 never pends
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) pend_q <= '0;
      else       pend_q <= pend_d;
   end

   assign o_rs1_pend = pend_byp[i_rs1_idx];
   assign o_rs2_pend = pend_byp[i_rs2_idx];
   assign o_rd_pend  = pend_byp[i_rd_idx];

endmodule

// File: rtl/dispatch.sv
// rtl/dispatch.sv - single-entry issue stage with scoreboard hazard check and illegal-op trap
module dispatch
   import dispatch_pkg::*;
(
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_dec_vld,
   output logic                          o_dec_rdy,
   input  logic [CIRNO_DEC_OPB_SIZE-1:0] i_opb,
   input  logic [CIRNO_DEC_USELE-1:0]    i_usele,
   input  logic                          i_rs1_ren,
   input  logic                          i_rs2_ren,
   input  logic [4:0]                    i_rs1_idx,
   input  logic [4:0]                    i_rs2_idx,
   input  logic [4:0]                    i_rd_idx,
   input  logic [31:0]                   i_im,
   input  logic [31:0]                   i_pc,
   input  logic                          i_ilgl,
   input  logic                          i_val,
   output logic                          o_iss_vld,
   output logic [CIRNO_DEC_OPB_SIZE-1:0] o_iss_opb,
   output logic [CIRNO_DEC_USELE-1:0]    o_iss_usele,
   output logic [4:0]                    o_iss_rs1_idx,
   output logic [4:0]                    o_iss_rs2_idx,
   output logic [4:0]                    o_iss_rd_idx,
   output logic                          o_iss_rd_wen,
   output logic [31:0]                   o_iss_im,
   output logic [31:0]                   o_iss_pc,
   input  logic                          i_alu_rdy,
   input  logic                          i_bju_rdy,
   input  logic                          i_lsu_rdy,
   input  logic                          i_wb_vld,
   input  logic [4:0]                    i_wb_idx,
   output logic                          o_trap,
   output logic [31:0]                   o_trap_pc,
   input  logic                          i_flush,
   output logic [15:0]                   o_stall_cnt
);

   disp_state_e                   state_q;
   logic                          trap_q;
   logic [31:0]                   trap_pc_q;

   logic                          iss_vld_q,   iss_vld_d;
   logic [CIRNO_DEC_OPB_SIZE-1:0] iss_opb_q,   iss_opb_d;
   logic [CIRNO_DEC_USELE-1:0]    iss_usele_q, iss_usele_d;
   logic [4:0]                    iss_rs1_q,   iss_rs1_d;
   logic [4:0]                    iss_rs2_q,   iss_rs2_d;
   logic [4:0]                    iss_rd_q,    iss_rd_d;
   logic                          iss_wen_q,   iss_wen_d;
   logic [31:0]                   iss_im_q,    iss_im_d;
   logic [31:0]                   iss_pc_q,    iss_pc_d;
   logic [15:0]                   stall_cnt_q, stall_cnt_d;

   logic rd_wen_c;
   logic unit_rdy;
   logic issuing;
   logic rs1_pend;
   logic rs2_pend;
   logic rd_pend;
   logic hazard;
   logic dec_rdy;
   logic xfer;
   logic xfer_ilgl;
   logic load_iss;
   logic sb_set;

   assign rd_wen_c = i_val & (i_rd_idx != 5'd0) & rd_writes(i_opb, i_usele);

   assign unit_rdy = (iss_usele_q[USELE_ALU] & i_alu_rdy) |
                     (iss_usele_q[USELE_BJU] & i_bju_rdy) |
                     (iss_usele_q[USELE_LSU] & i_lsu_rdy);
   assign issuing  = iss_vld_q & unit_rdy;

   // Hazard only matters while something is being offered
   assign hazard   = i_dec_vld & ((i_rs1_ren & rs1_pend) |
                                  (i_rs2_ren & rs2_pend) |
                                  (rd_wen_c  & rd_pend));
   assign dec_rdy  = (state_q == ST_RUN) & ~hazard & (~iss_vld_q | issuing);

   // A flush in the same cycle drops the offered instruction entirely
   assign xfer      = i_dec_vld & dec_rdy & ~i_flush;
   assign xfer_ilgl = xfer & i_ilgl;
   assign load_iss  = xfer & i_val & ~i_ilgl;
   assign sb_set    = xfer & ~i_ilgl & rd_wen_c;

   dispatch_sb u_sb (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_set_en   (sb_set),
      .i_set_idx  (i_rd_idx),
      .i_clr_en   (i_wb_vld),
      .i_clr_idx  (i_wb_idx),
      .i_rs1_idx  (i_rs1_idx),
      .i_rs2_idx  (i_rs2_idx),
      .i_rd_idx   (i_rd_idx),
      .o_rs1_pend (rs1_pend),
      .o_rs2_pend (rs2_pend),
      .o_rd_pend  (rd_pend)
   );

   // Issue register next state: flush clears, accept loads, issue empties
   always_comb begin
      iss_vld_d   = iss_vld_q;
      iss_opb_d   = iss_opb_q;
      iss_usele_d = iss_usele_q;
      iss_rs1_d   = iss_rs1_q;
      iss_rs2_d   = iss_rs2_q;
      iss_rd_d    = iss_rd_q;
      iss_wen_d   = iss_wen_q;
      iss_im_d    = iss_im_q;
      iss_pc_d    = iss_pc_q;
      if (i_flush) begin
         iss_vld_d = 1'b0;
      end else if (load_iss) begin
         iss_vld_d   = 1'b1;
         iss_opb_d   = i_opb;
         iss_usele_d = i_usele;
         iss_rs1_d   = i_rs1_idx;
         iss_rs2_d   = i_rs2_idx;
         iss_rd_d    = i_rd_idx;
         iss_wen_d   = rd_wen_c;
         iss_im_d    = i_im;
         iss_pc_d    = i_pc;
      end else if (issuing) begin
         iss_vld_d = 1'b0;
      end
   end

   // Issue register storage
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         iss_vld_q   <= 1'b0;
         iss_opb_q   <= '0;
         iss_usele_q <= '0;
         iss_rs1_q   <= '0;
         iss_rs2_q   <= '0;
         iss_rd_q    <= '0;
         iss_wen_q   <= 1'b0;
         iss_im_q    <= '0;
         iss_pc_q    <= '0;
      end else begin
         iss_vld_q   <= iss_vld_d;
         iss_opb_q   <= iss_opb_d;
         iss_usele_q <= iss_usele_d;
         iss_rs1_q   <= iss_rs1_d;
         iss_rs2_q   <= iss_rs2_d;
         iss_rd_q    <= iss_rd_d;
         iss_wen_q   <= iss_wen_d;
         iss_im_q    <= iss_im_d;
         iss_pc_q    <= iss_pc_d;
      end
   end

   // RUN/TRAP control with registered one-cycle trap pulse
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= ST_RUN;
         trap_q    <= 1'b0;
         trap_pc_q <= '0;
      end else begin
         trap_q <= xfer_ilgl;
         if (xfer_ilgl) trap_pc_q <= i_pc;
         case (state_q)
            ST_RUN:  if (xfer_ilgl) state_q <= ST_TRAP;
            ST_TRAP: if (i_flush)   state_q <= ST_RUN;
            default: state_q <= ST_RUN;
         endcase
      end
   end

   // Saturating count of cycles where decode offers but is not accepted
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (i_dec_vld && !dec_rdy && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
   end

   // Stall counter storage
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign o_dec_rdy     = dec_rdy;
   assign o_iss_vld     = iss_vld_q;
   assign o_iss_opb     = iss_opb_q;
   assign o_iss_usele   = iss_usele_q;
   assign o_iss_rs1_idx = iss_rs1_q;
   assign o_iss_rs2_idx = iss_rs2_q;
   assign o_iss_rd_idx  = iss_rd_q;
   assign o_iss_rd_wen  = iss_wen_q;
   assign o_iss_im      = iss_im_q;
   assign o_iss_pc      = iss_pc_q;
   assign o_trap        = trap_q;
   assign o_trap_pc     = trap_pc_q;
   assign o_stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_dispatch.sv
// tb/tb_dispatch.sv - table-driven and scoreboard-checked bench for dispatch
module tb_dispatch;
   import dispatch_pkg::*;

   logic                          i_clk = 1'b0;
   logic                          i_rst;
   logic                          i_dec_vld;
   logic                          o_dec_rdy;
   logic [CIRNO_DEC_OPB_SIZE-1:0] i_opb;
   logic [CIRNO_DEC_USELE-1:0]    i_usele;
   logic                          i_rs1_ren, i_rs2_ren;
   logic [4:0]                    i_rs1_idx, i_rs2_idx, i_rd_idx;
   logic [31:0]                   i_im, i_pc;
   logic                          i_ilgl, i_val;
   logic                          o_iss_vld;
   logic [CIRNO_DEC_OPB_SIZE-1:0] o_iss_opb;
   logic [CIRNO_DEC_USELE-1:0]    o_iss_usele;
   logic [4:0]                    o_iss_rs1_idx, o_iss_rs2_idx, o_iss_rd_idx;
   logic                          o_iss_rd_wen;
   logic [31:0]                   o_iss_im, o_iss_pc;
   logic                          i_alu_rdy, i_bju_rdy, i_lsu_rdy;
   logic                          i_wb_vld;
   logic [4:0]                    i_wb_idx;
   logic                          o_trap;
   logic [31:0]                   o_trap_pc;
   logic                          i_flush;
   logic [15:0]                   o_stall_cnt;

   dispatch dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_dec_vld(i_dec_vld), .o_dec_rdy(o_dec_rdy),
      .i_opb(i_opb), .i_usele(i_usele), .i_rs1_ren(i_rs1_ren), .i_rs2_ren(i_rs2_ren),
      .i_rs1_idx(i_rs1_idx), .i_rs2_idx(i_rs2_idx), .i_rd_idx(i_rd_idx),
      .i_im(i_im), .i_pc(i_pc), .i_ilgl(i_ilgl), .i_val(i_val),
      .o_iss_vld(o_iss_vld), .o_iss_opb(o_iss_opb), .o_iss_usele(o_iss_usele),
      .o_iss_rs1_idx(o_iss_rs1_idx), .o_iss_rs2_idx(o_iss_rs2_idx), .o_iss_rd_idx(o_iss_rd_idx),
      .o_iss_rd_wen(o_iss_rd_wen), .o_iss_im(o_iss_im), .o_iss_pc(o_iss_pc),
      .i_alu_rdy(i_alu_rdy), .i_bju_rdy(i_bju_rdy), .i_lsu_rdy(i_lsu_rdy),
      .i_wb_vld(i_wb_vld), .i_wb_idx(i_wb_idx), .o_trap(o_trap), .o_trap_pc(o_trap_pc),
      .i_flush(i_flush), .o_stall_cnt(o_stall_cnt)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int          opb_bit;
      int          unit;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] pc;
      logic        val, ilgl, exp_wen;
   } instr_t;

   typedef struct {
      logic [CIRNO_DEC_OPB_SIZE-1:0] opb;
      logic [CIRNO_DEC_USELE-1:0]    usele;
      logic [4:0]                    rs1, rs2, rd;
      logic                          wen;
      logic [31:0]                   im, pc;
   } iss_t;

   iss_t   exp_q[$];
   instr_t tbl[11];
   int     n_tests = 0;
   int     n_fail  = 0;
   int     exp_stall = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic instr_t mk(input int opb_bit, input int unit, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] pc,
                                 input logic val, input logic ilgl, input logic exp_wen);
      instr_t t;
      t.opb_bit = opb_bit; t.unit = unit; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
      t.pc = pc; t.val = val; t.ilgl = ilgl; t.exp_wen = exp_wen;
      return t;
   endfunction

   task automatic apply(input instr_t t);
      i_opb = '0;
      i_opb[t.opb_bit] = 1'b1;
      i_usele = '0;
      i_usele[t.unit] = 1'b1;
      i_rs1_ren = 1'b1; i_rs2_ren = 1'b1;
      i_rs1_idx = t.rs1; i_rs2_idx = t.rs2; i_rd_idx = t.rd;
      i_im = t.pc ^ 32'h5A5A_0000;
      i_pc = t.pc; i_val = t.val; i_ilgl = t.ilgl;
   endtask

   task automatic push_exp(input instr_t t);
      iss_t e;
      e.opb = '0;
      e.opb[t.opb_bit] = 1'b1;
      e.usele = '0;
      e.usele[t.unit] = 1'b1;
      e.rs1 = t.rs1; e.rs2 = t.rs2; e.rd = t.rd; e.wen = t.exp_wen;
      e.im = t.pc ^ 32'h5A5A_0000; e.pc = t.pc;
      exp_q.push_back(e);
   endtask

   // Offer an instruction until accepted (bounded)
   task automatic send(input instr_t t);
      bit ok = 0;
      apply(t);
      i_dec_vld = 1'b1;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge i_clk);
         if (o_dec_rdy) begin
            if (t.val && !t.ilgl) push_exp(t);
            ok = 1;
         end
         @(posedge i_clk); #1;
      end
      i_dec_vld = 1'b0;
      if (!ok) chk("send_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_drain();
      bit ok = 0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge i_clk);
         if (exp_q.size() == 0) ok = 1;
      end
      @(posedge i_clk); #1;
      if (!ok) chk("issue_drain_timeout", exp_q.size(), 32'd0);
   endtask

   task automatic wb(input logic [4:0] idx);
      i_wb_vld = 1'b1; i_wb_idx = idx;
      @(posedge i_clk); #1;
      i_wb_vld = 1'b0;
   endtask

   // Issue monitor: compare every issued instruction with the expected queue
   always @(negedge i_clk) begin
      if (!i_rst && o_iss_vld &&
          ((o_iss_usele[USELE_ALU] & i_alu_rdy) | (o_iss_usele[USELE_BJU] & i_bju_rdy) |
           (o_iss_usele[USELE_LSU] & i_lsu_rdy))) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_issue_pc", o_iss_pc, 32'hFFFF_FFFF);
         end else begin
            iss_t e;
            e = exp_q.pop_front();
            chk("iss_pc", o_iss_pc, e.pc);
            chk("iss_opb", 32'(o_iss_opb), 32'(e.opb));
            chk("iss_usele", 32'(o_iss_usele), 32'(e.usele));
            chk("iss_rs1", 32'(o_iss_rs1_idx), 32'(e.rs1));
            chk("iss_rs2", 32'(o_iss_rs2_idx), 32'(e.rs2));
            chk("iss_rd", 32'(o_iss_rd_idx), 32'(e.rd));
            chk("iss_rd_wen", 32'(o_iss_rd_wen), 32'(e.wen));
            chk("iss_im", o_iss_im, e.im);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      instr_t t;
      tbl[0]  = mk(OPB_ADD,   USELE_ALU, 5'd1, 5'd2, 5'd3,  32'h100, 1'b1, 1'b0, 1'b1);
      tbl[1]  = mk(OPB_ADD,   USELE_ALU, 5'd1, 5'd2, 5'd0,  32'h104, 1'b1, 1'b0, 1'b0);
      tbl[2]  = mk(OPB_LW,    USELE_LSU, 5'd1, 5'd2, 5'd4,  32'h108, 1'b1, 1'b0, 1'b1);
      tbl[3]  = mk(OPB_LBU,   USELE_LSU, 5'd1, 5'd2, 5'd8,  32'h10C, 1'b1, 1'b0, 1'b1);
      tbl[4]  = mk(OPB_SW,    USELE_LSU, 5'd1, 5'd2, 5'd9,  32'h110, 1'b1, 1'b0, 1'b0);
      tbl[5]  = mk(OPB_JAL,   USELE_BJU, 5'd1, 5'd2, 5'd1,  32'h114, 1'b1, 1'b0, 1'b1);
      tbl[6]  = mk(OPB_JALR,  USELE_BJU, 5'd1, 5'd2, 5'd31, 32'h118, 1'b1, 1'b0, 1'b1);
      tbl[7]  = mk(OPB_AUIPC, USELE_BJU, 5'd1, 5'd2, 5'd2,  32'h11C, 1'b1, 1'b0, 1'b1);
      tbl[8]  = mk(OPB_BEQ,   USELE_BJU, 5'd1, 5'd2, 5'd3,  32'h120, 1'b1, 1'b0, 1'b0);
      tbl[9]  = mk(OPB_LUI,   USELE_ALU, 5'd1, 5'd2, 5'd5,  32'h124, 1'b1, 1'b0, 1'b1);
      tbl[10] = mk(OPB_LHU,   USELE_LSU, 5'd1, 5'd2, 5'd0,  32'h128, 1'b1, 1'b0, 1'b0);

      i_rst = 1'b1; i_dec_vld = 1'b0; i_flush = 1'b0; i_wb_vld = 1'b0; i_wb_idx = '0;
      i_alu_rdy = 1'b1; i_bju_rdy = 1'b1; i_lsu_rdy = 1'b1;
      apply(mk(OPB_ADD, USELE_ALU, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0));

      // Reset state
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      chk("rst_iss_vld", 32'(o_iss_vld), 32'd0);
      chk("rst_iss_opb", 32'(o_iss_opb), 32'd0);
      chk("rst_iss_pc", o_iss_pc, 32'd0);
      chk("rst_trap", 32'(o_trap), 32'd0);
      chk("rst_trap_pc", o_trap_pc, 32'd0);
      chk("rst_stall_cnt", 32'(o_stall_cnt), 32'd0);
      @(posedge i_clk); #1; i_rst = 1'b0;
      @(negedge i_clk);
      chk("rst_dec_rdy", 32'(o_dec_rdy), 32'd1);
      @(posedge i_clk); #1;

      // Table: rd_wen derivation across units and ops
      for (int i = 0; i < 11; i++) begin
         send(tbl[i]);
         wait_drain();
         if (tbl[i].exp_wen) wb(tbl[i].rd);
      end
      chk("table_stall_cnt", 32'(o_stall_cnt), 32'd0);

      // RAW hazard on x5, released by same-cycle writeback
      send(mk(OPB_ADD, USELE_ALU, 5'd1, 5'd2, 5'd5, 32'h200, 1'b1, 1'b0, 1'b1));
      t = mk(OPB_ADD, USELE_ALU, 5'd5, 5'd0, 5'd6, 32'h204, 1'b1, 1'b0, 1'b1);
      apply(t); i_dec_vld = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge i_clk); chk("raw_held_rdy", 32'(o_dec_rdy), 32'd0);
         @(posedge i_clk); #1;
      end
      exp_stall += 3;
      i_wb_vld = 1'b1; i_wb_idx = 5'd5;
      @(negedge i_clk); chk("raw_wb_bypass_rdy", 32'(o_dec_rdy), 32'd1);
      push_exp(t);
      @(posedge i_clk); #1; i_wb_vld = 1'b0; i_dec_vld = 1'b0;
      @(negedge i_clk);
      chk("raw_issue_next_vld", 32'(o_iss_vld), 32'd1);
      chk("raw_issue_next_pc", o_iss_pc, 32'h204);
      wait_drain(); wb(5'd6);

      // Store waiting on x7
      send(mk(OPB_ADD, USELE_ALU, 5'd1, 5'd2, 5'd7, 32'h220, 1'b1, 1'b0, 1'b1));
      t = mk(OPB_SW, USELE_LSU, 5'd1, 5'd7, 5'd7, 32'h224, 1'b1, 1'b0, 1'b0);
      apply(t); i_dec_vld = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge i_clk); chk("sw_held_rdy", 32'(o_dec_rdy), 32'd0);
         @(posedge i_clk); #1;
      end
      exp_stall += 2;
      i_wb_vld = 1'b1; i_wb_idx = 5'd7;
      @(negedge i_clk); chk("sw_wb_rdy", 32'(o_dec_rdy), 32'd1);
      push_exp(t);
      @(posedge i_clk); #1; i_wb_vld = 1'b0; i_dec_vld = 1'b0;
      wait_drain();
      apply(mk(OPB_ADD, USELE_ALU, 5'd7, 5'd7, 5'd0, 32'h228, 1'b1, 1'b0, 1'b0));
      i_dec_vld = 1'b1;
      @(negedge i_clk); chk("x7_clear_rdy", 32'(o_dec_rdy), 32'd1);
      push_exp(mk(OPB_ADD, USELE_ALU, 5'd7, 5'd7, 5'd0, 32'h228, 1'b1, 1'b0, 1'b0));
      @(posedge i_clk); #1; i_dec_vld = 1'b0;
      wait_drain();

      // Nop is consumed without issue
      send(mk(OPB_ADD, USELE_ALU, 5'd0, 5'd0, 5'd0, 32'h240, 1'b0, 1'b0, 1'b0));
      @(negedge i_clk); chk("nop_no_issue", 32'(o_iss_vld), 32'd0);
      @(posedge i_clk); #1;

      // Issue held while ALU busy, BJU ready
      i_alu_rdy = 1'b0;
      send(mk(OPB_ADD, USELE_ALU, 5'd1, 5'd2, 5'd10, 32'h300, 1'b1, 1'b0, 1'b1));
      t = mk(OPB_ADD, USELE_ALU, 5'd1, 5'd2, 5'd11, 32'h304, 1'b1, 1'b0, 1'b1);
      apply(t); i_dec_vld = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge i_clk);
         chk("busy_iss_vld", 32'(o_iss_vld), 32'd1);
         chk("busy_iss_pc", o_iss_pc, 32'h300);
         chk("busy_dec_rdy", 32'(o_dec_rdy), 32'd0);
         @(posedge i_clk); #1;
      end
      exp_stall += 3;
      i_alu_rdy = 1'b1;
      @(negedge i_clk); chk("busy_release_rdy", 32'(o_dec_rdy), 32'd1);
      push_exp(t);
      @(posedge i_clk); #1; i_dec_vld = 1'b0;
      wait_drain(); wb(5'd10); wb(5'd11);

      // Illegal instruction trap and flush recovery
      send(mk(OPB_ADD, USELE_ALU, 5'd0, 5'd0, 5'd0, 32'h80, 1'b1, 1'b1, 1'b0));
      apply(mk(OPB_ADD, USELE_ALU, 5'd1, 5'd2, 5'd0, 32'h84, 1'b1, 1'b0, 1'b0));
      i_dec_vld = 1'b1;
      @(negedge i_clk);
      chk("trap_pulse", 32'(o_trap), 32'd1);
      chk("trap_pc", o_trap_pc, 32'h80);
      chk("trap_rdy0", 32'(o_dec_rdy), 32'd0);
      chk("trap_no_issue", 32'(o_iss_vld), 32'd0);
      @(posedge i_clk); #1;
      @(negedge i_clk);
      chk("trap_pulse_end", 32'(o_trap), 32'd0);
      chk("trap_rdy1", 32'(o_dec_rdy), 32'd0);
      @(posedge i_clk); #1;
      exp_stall += 2;
      i_dec_vld = 1'b0; i_flush = 1'b1;
      @(posedge i_clk); #1; i_flush = 1'b0;
      @(negedge i_clk); chk("post_flush_rdy", 32'(o_dec_rdy), 32'd1);
      @(posedge i_clk); #1;
      send(mk(OPB_ADD, USELE_ALU, 5'd1, 5'd2, 5'd0, 32'h88, 1'b1, 1'b0, 1'b0));
      wait_drain();

      // Flush empties a stuck issue register but keeps its scoreboard bit
      i_alu_rdy = 1'b0;
      send(mk(OPB_ADD, USELE_ALU, 5'd1, 5'd2, 5'd12, 32'h400, 1'b1, 1'b0, 1'b1));
      i_flush = 1'b1;
      @(posedge i_clk); #1; i_flush = 1'b0;
      exp_q.delete();
      i_alu_rdy = 1'b1;
      @(negedge i_clk); chk("flush_clears_iss", 32'(o_iss_vld), 32'd0);
      @(posedge i_clk); #1;
      // Flush overrides a same-cycle transfer
      apply(mk(OPB_ADD, USELE_ALU, 5'd1, 5'd2, 5'd13, 32'h404, 1'b1, 1'b0, 1'b1));
      i_dec_vld = 1'b1; i_flush = 1'b1;
      @(posedge i_clk); #1; i_dec_vld = 1'b0; i_flush = 1'b0;
      @(negedge i_clk); chk("flush_drops_xfer", 32'(o_iss_vld), 32'd0);
      @(posedge i_clk); #1;
      apply(mk(OPB_ADD, USELE_ALU, 5'd13, 5'd12, 5'd0, 32'h408, 1'b1, 1'b0, 1'b0));
      i_dec_vld = 1'b1;
      @(negedge i_clk); chk("x12_retained_rdy", 32'(o_dec_rdy), 32'd0);
      @(posedge i_clk); #1;
      exp_stall += 1;
      i_wb_vld = 1'b1; i_wb_idx = 5'd12;
      @(negedge i_clk); chk("x13_never_set_rdy", 32'(o_dec_rdy), 32'd1);
      push_exp(mk(OPB_ADD, USELE_ALU, 5'd13, 5'd12, 5'd0, 32'h408, 1'b1, 1'b0, 1'b0));
      @(posedge i_clk); #1; i_wb_vld = 1'b0; i_dec_vld = 1'b0;
      wait_drain();
      chk("stall_cnt_total", 32'(o_stall_cnt), 32'(exp_stall));

      // Asynchronous reset with x9 pending and issue register full
      i_alu_rdy = 1'b0;
      send(mk(OPB_ADD, USELE_ALU, 5'd1, 5'd2, 5'd9, 32'h500, 1'b1, 1'b0, 1'b1));
      i_rst = 1'b1;
      #1;
      chk("async_rst_iss_vld", 32'(o_iss_vld), 32'd0);
      chk("async_rst_stall", 32'(o_stall_cnt), 32'd0);
      exp_q.delete();
      @(posedge i_clk); #1; i_rst = 1'b0;
      t = mk(OPB_ADD, USELE_ALU, 5'd9, 5'd9, 5'd14, 32'h504, 1'b1, 1'b0, 1'b1);
      apply(t); i_dec_vld = 1'b1;
      @(negedge i_clk); chk("x9_cleared_rdy", 32'(o_dec_rdy), 32'd1);
      push_exp(t);
      @(posedge i_clk); #1;

      // Stall counter saturation: issue register stuck, decode keeps offering
      apply(mk(OPB_ADD, USELE_ALU, 5'd1, 5'd2, 5'd15, 32'h508, 1'b1, 1'b0, 1'b1));
      repeat (65540) @(posedge i_clk);
      #1;
      chk("stall_cnt_saturate", 32'(o_stall_cnt), 32'h0000_FFFF);
      i_dec_vld = 1'b0;
      i_alu_rdy = 1'b1;
      wait_drain();
      chk("final_queue_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dispatch.md
DISPATCH -- requirements
Module: dispatch

Interface
REQ-001 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-002 i_rst  in  1  reset, asynchronous, active-high.
REQ-003 i_dec_vld  in  1  decoded instruction present; o_dec_rdy  out  1  dispatch accepts it this cycle.
REQ-004 i_opb  in  CIRNO_DEC_OPB_SIZE  one-hot op bus; i_usele  in  CIRNO_DEC_USELE  unit select (ALU/BJU/LSU).
REQ-005 i_rs1_ren, i_rs2_ren  in  1 each  source-read enables; i_rs1_idx, i_rs2_idx, i_rd_idx  in  5 each  register indices.
REQ-006 i_im  in  32  immediate; i_pc  in  32  instruction PC; i_ilgl  in  1  illegal flag; i_val  in  1  instruction has effect (0 = nop).
REQ-007 o_iss_vld  out  1; o_iss_opb, o_iss_usele, o_iss_rs1_idx, o_iss_rs2_idx, o_iss_rd_idx, o_iss_rd_wen, o_iss_im, o_iss_pc  out  same widths as inputs (rd_wen 1).
REQ-008 i_alu_rdy, i_bju_rdy, i_lsu_rdy  in  1 each  per-unit accept.
REQ-009 i_wb_vld  in  1; i_wb_idx  in  5  writeback clears scoreboard bit.
REQ-010 o_trap  out  1  one-cycle illegal-instruction pulse; o_trap_pc  out  32.
REQ-011 i_flush  in  1  discard issue register and leave TRAP.
REQ-012 o_stall_cnt  out  16  cycles with i_dec_vld=1 and o_dec_rdy=0.

Function
REQ-013 Handshake: transfer when i_dec_vld & o_dec_rdy; issue when o_iss_vld & selected-unit rdy (unit chosen by o_iss_usele).
REQ-014 Issue register single entry; accepted instruction appears on o_iss_* next cycle (latency 1); held stable until issued.
REQ-015 rd_wen = i_val & (rd_idx != 0) & (usele ALU | LSU load op (LB,LH,LW,LBU,LHU) | BJU JAL/JALR/AUIP op).
REQ-016 Scoreboard: 32-bit pending vector, bit 0 always 0; set for rd_idx on transfer with rd_wen; cleared on i_wb_vld.
REQ-017 Hazard = (rs1_ren & pend[rs1]) | (rs2_ren & pend[rs2]) | (rd_wen & pend[rd]); pending evaluated after same-cycle writeback clear (wb bypass).
REQ-018 Same-cycle set and clear of one index: set wins.
REQ-019 o_dec_rdy = state RUN & ~hazard & (~o_iss_vld | issuing this cycle); when i_dec_vld=0 hazard is ignored (rdy computed from state and issue register).
REQ-020 Nop (i_val=0, i_ilgl=0) is consumed: o_iss_vld not set, scoreboard unchanged.
REQ-021 Illegal (i_ilgl=1) on transfer: not issued, no scoreboard change, o_trap=1 and o_trap_pc=i_pc next cycle, state -> TRAP.
REQ-022 States: RUN, TRAP. RUN->TRAP on illegal transfer; TRAP->RUN on i_flush; TRAP holds o_dec_rdy=0; issue register may still drain in TRAP.
REQ-023 i_flush (any state): o_iss_vld cleared next cycle, state RUN, scoreboard retained (in-flight writebacks still arrive); flush overrides a same-cycle transfer (transfer dropped, no scoreboard set).
REQ-024 o_stall_cnt increments by 1 per stall cycle, saturates at 16'hFFFF, never wraps.

Reset
REQ-025 On i_rst: state RUN, o_iss_vld=0, all o_iss_* fields 0, pending vector 0, o_trap=0, o_trap_pc=0, o_stall_cnt=0; o_dec_rdy=1 after release.
REQ-026 Reset mid-operation discards the issue register and all pending bits immediately (asynchronous).

Structure
REQ-027 Op-bus bit positions, unit-select indices and widths come from the shared cirno9 define file; no local duplicates.
REQ-028 Scoreboard is one sub-module, dispatch_sb (set/clear/query, 32 entries), instantiated once.

Verification
REQ-029 add x5 then addi x6,x5,1 back-to-back, no wb -> second held, o_dec_rdy=0, o_stall_cnt counts; i_wb_vld idx=5 -> second accepted same cycle, issues next cycle.
REQ-030 sw with rs2=x7 pending, i_lsu_rdy=1 -> stall until wb idx 7; then o_iss_rd_wen=0, x7 bit stays clear.
REQ-031 i_ilgl=1 at pc 0x80 -> o_trap=1 one cycle, o_trap_pc=0x80, o_dec_rdy=0 until i_flush, then 1.
REQ-032 addi x0,x0,0 (i_val=0) -> no o_iss_vld, pending vector stays 0.
REQ-033 o_iss_vld with ALU op and i_alu_rdy=0 for 3 cycles, i_bju_rdy=1 -> outputs stable 3 cycles, no new accept; issue on i_alu_rdy=1.
REQ-034 i_rst asserted while x9 pending and issue register full -> o_iss_vld=0 and o_dec_rdy=1 for instruction reading x9 after release.
